// File: rtl/bcd_conv_scheduler.sv
// Round-robin arbiter that feeds one binary-to-BCD converter from NUM_CH FIFOs,
// one job at a time, and returns each result tagged with its source channel.
module bcd_conv_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int BINARY_WIDTH   = 8,
    parameter int DECIMAL_DIGITS = 2,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int TAG_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BCD_W         = DECIMAL_DIGITS * 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_CH-1:0]              i_ch_empty,
    input  logic [NUM_CH-1:0]              i_ch_busy,
    input  logic [NUM_CH*BINARY_WIDTH-1:0] i_ch_data,
    output logic [NUM_CH-1:0]              o_ch_pop,
    output logic [BINARY_WIDTH-1:0]        o_conv_binary,
    output logic                           o_conv_empty_input,
    output logic                           o_conv_busy_input,
    input  logic                           i_conv_req_input,
    input  logic [BCD_W-1:0]               i_conv_bcd,
    input  logic                           i_conv_valid_output,
    output logic                           o_conv_busy_output,
    output logic                           o_conv_full_output,
    output logic [BCD_W-1:0]               o_res_bcd,
    output logic [TAG_W-1:0]               o_res_tag,
    output logic                           o_res_valid,
    input  logic                           i_res_ready,
    output logic                           o_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_OFFER,
        S_WAIT_RES
    } state_t;

    state_t                  r_state;
    state_t                  next_state;
    logic [TAG_W-1:0]        r_last;
    logic [BINARY_WIDTH-1:0] r_binary;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_valid_d;
    logic [NUM_CH-1:0]       eligible;
    logic                    gnt_found;
    logic [TAG_W-1:0]        gnt_idx;
    logic                    capture;
    logic                    timeout_hit;
    logic                    cnt_at_limit;

    assign eligible      = ~i_ch_empty & ~i_ch_busy;
    assign o_conv_binary = r_binary;
    assign cnt_at_limit  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Search starts one past the last grant so the previous winner ranks lowest.
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = r_last;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(r_last) + 1 + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!gnt_found && eligible[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = TAG_W'(j);
            end
        end
    end

    always_comb begin
        next_state         = r_state;
        capture            = 1'b0;
        timeout_hit        = 1'b0;
        o_conv_empty_input = 1'b1;
        o_conv_busy_input  = 1'b1;
        o_conv_busy_output = 1'b1;
        o_conv_full_output = 1'b0;
        case (r_state)
            S_IDLE:  if (gnt_found) next_state = S_POP;
            S_POP:   next_state = S_LATCH;
            S_LATCH: next_state = S_OFFER;
            S_OFFER: begin
                o_conv_empty_input = 1'b0;
                o_conv_busy_input  = 1'b0;
                if (i_conv_req_input) begin
                    next_state = S_WAIT_RES;
                end else if (cnt_at_limit) begin
                    timeout_hit = 1'b1;
                    next_state  = S_IDLE;
                end
            end
            S_WAIT_RES: begin
                o_conv_busy_output = 1'b0;
                o_conv_full_output = o_res_valid;
                if (i_conv_valid_output && !r_valid_d) begin
                    capture    = 1'b1;
                    next_state = S_IDLE;
                end else if (!o_res_valid && cnt_at_limit) begin
                    timeout_hit = 1'b1;
                    next_state  = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_last      <= TAG_W'(NUM_CH - 1);
            r_binary    <= '0;
            r_cnt       <= '0;
            r_valid_d   <= 1'b0;
            o_ch_pop    <= '0;
            o_res_bcd   <= '0;
            o_res_tag   <= '0;
            o_res_valid <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            r_state   <= next_state;
            r_valid_d <= i_conv_valid_output;
            o_timeout <= timeout_hit;
            o_ch_pop  <= '0;
            if (r_state == S_IDLE && gnt_found) begin
                o_ch_pop <= NUM_CH'(1) << gnt_idx;
                r_last   <= gnt_idx;
            end
            if (r_state == S_LATCH) begin
                r_binary <= i_ch_data[int'(r_last)*BINARY_WIDTH +: BINARY_WIDTH];
            end
            // Frozen while a result waits downstream: backpressure is not a stall.
            if (next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_OFFER || (r_state == S_WAIT_RES && !o_res_valid)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (capture) begin
                o_res_bcd   <= i_conv_bcd;
                o_res_tag   <= r_last;
                o_res_valid <= 1'b1;
            end else if (o_res_valid && i_res_ready) begin
                o_res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler: FIFO and converter models plus
// one task per scenario with hand-computed expected results.
module tb_bcd_conv_scheduler;

    localparam int NUM_CH   = 4;
    localparam int BW       = 8;
    localparam int TIMEOUT  = 64;
    localparam int CONV_LAT = 3;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NUM_CH-1:0] i_ch_empty;
    logic [NUM_CH-1:0] i_ch_busy;
    logic [NUM_CH*BW-1:0] i_ch_data;
    logic [NUM_CH-1:0] o_ch_pop;
    logic [BW-1:0]     o_conv_binary;
    logic              o_conv_empty_input;
    logic              o_conv_busy_input;
    logic              i_conv_req_input;
    logic [7:0]        i_conv_bcd;
    logic              i_conv_valid_output;
    logic              o_conv_busy_output;
    logic              o_conv_full_output;
    logic [7:0]        o_res_bcd;
    logic [1:0]        o_res_tag;
    logic              o_res_valid;
    logic              i_res_ready;
    logic              o_timeout;

    bcd_conv_scheduler #(
        .NUM_CH(NUM_CH), .BINARY_WIDTH(BW), .DECIMAL_DIGITS(2), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ch_empty(i_ch_empty), .i_ch_busy(i_ch_busy), .i_ch_data(i_ch_data),
        .o_ch_pop(o_ch_pop), .o_conv_binary(o_conv_binary),
        .o_conv_empty_input(o_conv_empty_input), .o_conv_busy_input(o_conv_busy_input),
        .i_conv_req_input(i_conv_req_input), .i_conv_bcd(i_conv_bcd),
        .i_conv_valid_output(i_conv_valid_output),
        .o_conv_busy_output(o_conv_busy_output), .o_conv_full_output(o_conv_full_output),
        .o_res_bcd(o_res_bcd), .o_res_tag(o_res_tag), .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [BW-1:0] fifo_q [NUM_CH][$];
    logic [BW-1:0] ch_rd  [NUM_CH];
    int  pop_cnt [NUM_CH];
    int  pop_log [$];
    int  timeout_cnt = 0;
    int  onehot_err  = 0;
    bit  conv_req_en = 1'b1;
    bit  m_busy      = 1'b0;
    int  m_cnt       = 0;
    logic [BW-1:0] m_word;

    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        int x;
        x = int'(v) % 100;
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    // FIFO and converter models, updated on the falling edge.
    always @(negedge i_clk) begin
        if (i_rst) begin
            m_busy              = 1'b0;
            i_conv_req_input    = 1'b0;
            i_conv_valid_output = 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (o_ch_pop[k]) begin
                    pop_cnt[k]++;
                    pop_log.push_back(k);
                    if (fifo_q[k].size() > 0) ch_rd[k] = fifo_q[k].pop_front();
                end
            end
            if ($countones(o_ch_pop) > 1) onehot_err++;
            if (o_timeout) timeout_cnt++;
            i_conv_valid_output = 1'b0;
            if (m_busy) begin
                if (m_cnt > 0) m_cnt--;
                else if (!o_conv_busy_output && !o_conv_full_output) begin
                    i_conv_valid_output = 1'b1;
                    i_conv_bcd          = to_bcd(m_word);
                    m_busy              = 1'b0;
                end
            end
            i_conv_req_input = 1'b0;
            if (conv_req_en && !m_busy && !o_conv_empty_input && !o_conv_busy_input) begin
                i_conv_req_input = 1'b1;
                m_busy           = 1'b1;
                m_word           = o_conv_binary;
                m_cnt            = CONV_LAT;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            i_ch_empty[k]        = (fifo_q[k].size() == 0);
            i_ch_data[k*BW +: BW] = ch_rd[k];
        end
    end

    task automatic get_result(output logic [7:0] bcd, output logic [1:0] tag);
        bcd = 'x;
        tag = 'x;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            if (o_res_valid) begin
                bcd         = o_res_bcd;
                tag         = o_res_tag;
                i_res_ready = 1'b1;
                @(negedge i_clk);
                i_res_ready = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge i_clk);
        n_checks++; if (o_ch_pop !== 4'b0) $display("FAIL rst_pop got %b want 0000", o_ch_pop); else n_pass++;
        n_checks++; if (o_conv_empty_input !== 1'b1) $display("FAIL rst_empty_in got %b want 1", o_conv_empty_input); else n_pass++;
        n_checks++; if (o_conv_busy_input !== 1'b1) $display("FAIL rst_busy_in got %b want 1", o_conv_busy_input); else n_pass++;
        n_checks++; if (o_conv_busy_output !== 1'b1) $display("FAIL rst_busy_out got %b want 1", o_conv_busy_output); else n_pass++;
        n_checks++; if (o_conv_full_output !== 1'b0) $display("FAIL rst_full got %b want 0", o_conv_full_output); else n_pass++;
        n_checks++; if (o_res_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", o_res_valid); else n_pass++;
        n_checks++; if (o_timeout !== 1'b0) $display("FAIL rst_timeout got %b want 0", o_timeout); else n_pass++;
        n_checks++; if ({o_conv_binary, o_res_bcd, o_res_tag} !== 18'h0) $display("FAIL rst_data got %h/%h/%h want 0", o_conv_binary, o_res_bcd, o_res_tag); else n_pass++;
        i_rst = 1'b0;
    endtask

    task automatic test_single();
        fifo_q[0].push_back(8'hFF);
        for (int i = 0; i < 100 && !o_res_valid; i++) @(negedge i_clk);
        n_checks++; if (o_res_bcd !== 8'h55) $display("FAIL single_bcd got %h want 55", o_res_bcd); else n_pass++;
        n_checks++; if (o_res_tag !== 2'd0) $display("FAIL single_tag got %0d want 0", o_res_tag); else n_pass++;
        repeat (5) @(negedge i_clk);
        n_checks++; if (o_res_valid !== 1'b1 || o_res_bcd !== 8'h55) $display("FAIL single_hold got v=%b bcd=%h want v=1 bcd=55", o_res_valid, o_res_bcd); else n_pass++;
        i_res_ready = 1'b1;
        @(negedge i_clk);
        i_res_ready = 1'b0;
        n_checks++; if (o_res_valid !== 1'b0) $display("FAIL single_drain got %b want 0", o_res_valid); else n_pass++;
        n_checks++; if (pop_cnt[0] !== 1) $display("FAIL single_pops got %0d want 1", pop_cnt[0]); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_bcd [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        logic [1:0] exp_tag [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] b;
        logic [1:0] t;
        do_reset();
        fifo_q[0].push_back(8'd10);
        fifo_q[0].push_back(8'd50);
        fifo_q[1].push_back(8'd20);
        fifo_q[2].push_back(8'd30);
        fifo_q[3].push_back(8'd40);
        for (int i = 0; i < 5; i++) begin
            get_result(b, t);
            n_checks++; if (b !== exp_bcd[i] || t !== exp_tag[i]) $display("FAIL rr_%0d got bcd=%h tag=%0d want bcd=%h tag=%0d", i, b, t, exp_bcd[i], exp_tag[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int tos = 0;
        logic [7:0] b;
        logic [1:0] t;
        fifo_q[1].push_back(8'd25);
        fifo_q[2].push_back(8'd99);
        repeat (200) begin
            @(negedge i_clk);
            if (o_timeout) tos++;
        end
        n_checks++; if (tos !== 0) $display("FAIL bp_timeout got %0d want 0", tos); else n_pass++;
        n_checks++; if (o_res_valid !== 1'b1 || o_res_bcd !== 8'h25 || o_res_tag !== 2'd1) $display("FAIL bp_first got v=%b bcd=%h tag=%0d want v=1 bcd=25 tag=1", o_res_valid, o_res_bcd, o_res_tag); else n_pass++;
        n_checks++; if (o_conv_full_output !== 1'b1 || o_conv_busy_output !== 1'b0) $display("FAIL bp_full got full=%b busy=%b want full=1 busy=0", o_conv_full_output, o_conv_busy_output); else n_pass++;
        get_result(b, t);
        n_checks++; if (b !== 8'h25 || t !== 2'd1) $display("FAIL bp_res0 got bcd=%h tag=%0d want 25/1", b, t); else n_pass++;
        get_result(b, t);
        n_checks++; if (b !== 8'h99 || t !== 2'd2) $display("FAIL bp_res1 got bcd=%h tag=%0d want 99/2", b, t); else n_pass++;
    endtask

    task automatic test_timeout();
        int n = 0;
        int t0;
        logic [7:0] b;
        logic [1:0] t;
        t0 = timeout_cnt;
        conv_req_en = 1'b0;
        fifo_q[3].push_back(8'd7);
        fifo_q[0].push_back(8'd8);
        for (int i = 0; i < 50 && o_conv_empty_input; i++) @(negedge i_clk);
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            n++;
            if (o_timeout) break;
        end
        conv_req_en = 1'b1;
        n_checks++; if (n !== TIMEOUT) $display("FAIL to_latency got %0d want %0d", n, TIMEOUT); else n_pass++;
        @(negedge i_clk);
        n_checks++; if (o_timeout !== 1'b0) $display("FAIL to_pulse_width got %b want 0", o_timeout); else n_pass++;
        get_result(b, t);
        n_checks++; if (b !== 8'h08 || t !== 2'd0) $display("FAIL to_next got bcd=%h tag=%0d want 08/0", b, t); else n_pass++;
        n_checks++; if (timeout_cnt - t0 !== 1) $display("FAIL to_count got %0d want 1", timeout_cnt - t0); else n_pass++;
    endtask

    task automatic test_busy_skip();
        int p2;
        int first;
        logic [7:0] b;
        logic [1:0] t;
        fifo_q[1].push_back(8'd11);
        get_result(b, t);
        n_checks++; if (b !== 8'h11 || t !== 2'd1) $display("FAIL bs_setup got bcd=%h tag=%0d want 11/1", b, t); else n_pass++;
        p2 = pop_cnt[2];
        pop_log.delete();
        i_ch_busy = 4'b0100;
        fifo_q[1].push_back(8'd12);
        fifo_q[2].push_back(8'd13);
        fifo_q[3].push_back(8'd14);
        get_result(b, t);
        n_checks++; if (b !== 8'h14 || t !== 2'd3) $display("FAIL bs_first got bcd=%h tag=%0d want 14/3", b, t); else n_pass++;
        first = (pop_log.size() > 0) ? pop_log[0] : -1;
        n_checks++; if (first !== 3) $display("FAIL bs_first_pop got %0d want 3", first); else n_pass++;
        get_result(b, t);
        n_checks++; if (b !== 8'h12 || t !== 2'd1) $display("FAIL bs_second got bcd=%h tag=%0d want 12/1", b, t); else n_pass++;
        repeat (10) @(negedge i_clk);
        n_checks++; if (pop_cnt[2] !== p2) $display("FAIL bs_ch2_pops got %0d want %0d", pop_cnt[2], p2); else n_pass++;
        i_ch_busy = 4'b0000;
        get_result(b, t);
        n_checks++; if (b !== 8'h13 || t !== 2'd2) $display("FAIL bs_release got bcd=%h tag=%0d want 13/2", b, t); else n_pass++;
    endtask

    task automatic test_reset_mid_job();
        logic [7:0] b;
        logic [1:0] t;
        fifo_q[0].push_back(8'd42);
        fifo_q[1].push_back(8'd43);
        for (int i = 0; i < 100 && !o_res_valid; i++) @(negedge i_clk);
        for (int i = 0; i < 100 && !o_conv_full_output; i++) @(negedge i_clk);
        n_checks++; if (o_conv_full_output !== 1'b1) $display("FAIL rm_stalled got %b want 1", o_conv_full_output); else n_pass++;
        #1 i_rst = 1'b1;
        #1;
        n_checks++; if (o_res_valid !== 1'b0 || o_conv_full_output !== 1'b0) $display("FAIL rm_async_res got v=%b full=%b want 0/0", o_res_valid, o_conv_full_output); else n_pass++;
        n_checks++; if (o_conv_busy_output !== 1'b1 || o_conv_empty_input !== 1'b1) $display("FAIL rm_async_conv got busy=%b empty=%b want 1/1", o_conv_busy_output, o_conv_empty_input); else n_pass++;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        fifo_q[2].push_back(8'd77);
        get_result(b, t);
        n_checks++; if (b !== 8'h77 || t !== 2'd2) $display("FAIL rm_after got bcd=%h tag=%0d want 77/2", b, t); else n_pass++;
        n_checks++; if (onehot_err !== 0) $display("FAIL pop_onehot got %0d errors want 0", onehot_err); else n_pass++;
    endtask

    initial begin
        i_rst       = 1'b1;
        i_ch_busy   = '0;
        i_res_ready = 1'b0;
        i_conv_req_input    = 1'b0;
        i_conv_valid_output = 1'b0;
        i_conv_bcd  = '0;
        i_ch_empty  = '1;
        i_ch_data   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_rd[k]   = '0;
            pop_cnt[k] = 0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_busy_skip();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
